// File: rtl/radar_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : radar_sync_pkg
// Brief    : Shared state encoding for the radar sync controller.
// Revision : 1.0 - initial release
// ============================================================================
package radar_sync_pkg;

    localparam int unsigned C_STATE_W = 3;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_ARP    = 3'd1,
        ST_CALIBRATING = 3'd2,
        ST_LOCKED      = 3'd3,
        ST_FAULT       = 3'd4
    } sync_state_e;

endpackage
`default_nettype wire

// File: rtl/arp_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : arp_watchdog
// Brief    : Microsecond timer since last ARP pulse, saturating, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module arp_watchdog #(
    parameter int unsigned TIMEOUT_US = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_clear,
    input  logic i_arp_pulse,
    input  logic i_us_tick,
    output logic o_timeout
);
    localparam int unsigned     C_TW    = $clog2(TIMEOUT_US + 1);
    localparam logic [C_TW-1:0] C_LIMIT = C_TW'(TIMEOUT_US);

    logic [C_TW-1:0] timer_q, timer_d;

    // An ARP restarts the count; a coincident tick is the first microsecond
    // of the new revolution.
    always_comb begin
        timer_d = timer_q;
        if (i_clear) begin
            timer_d = '0;
        end else if (i_active) begin
            if (i_arp_pulse) begin
                timer_d = i_us_tick ? C_TW'(1) : '0;
            end else if (i_us_tick && (timer_q != C_LIMIT)) begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign o_timeout = i_active && !i_arp_pulse && (timer_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/radar_sync_controller.sv
`default_nettype none
// ============================================================================
// Module   : radar_sync_controller
// Brief    : Calibration/lock sequencer that gates the radar simulator.
// Revision : 1.0 - initial release
// ============================================================================
module radar_sync_controller
    import radar_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LOCK_REVS      = 3,
    parameter int unsigned MAX_CAL_REVS   = 16,
    parameter int unsigned ARP_TIMEOUT_US = 20000000,
    parameter int unsigned ACP_MIN        = 256,
    parameter int unsigned ACP_MAX        = 8192,
    parameter int unsigned TRIG_MIN       = 1,
    parameter int unsigned ARP_TOL_US     = 1000
) (
    input  logic                  SYS_CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  ARP_PULSE,
    input  logic                  US_TICK,
    input  logic                  CALIBRATED,
    input  logic [DATA_WIDTH-1:0] ARP_US,
    input  logic [DATA_WIDTH-1:0] ACP_CNT,
    input  logic [DATA_WIDTH-1:0] TRIG_CNT,
    output logic [C_STATE_W-1:0]  STATE,
    output logic                  READY,
    output logic                  SIM_EN,
    output logic                  ERR_TIMEOUT,
    output logic                  ERR_UNSTABLE,
    output logic                  LOST_LOCK,
    output logic [15:0]           LOSS_CNT,
    output logic [DATA_WIDTH-1:0] LOCK_ARP_US,
    output logic [DATA_WIDTH-1:0] LOCK_ACP_CNT,
    output logic [DATA_WIDTH-1:0] LOCK_TRIG_CNT
);
    localparam int unsigned C_GW  = $clog2(LOCK_REVS + 1);
    localparam int unsigned C_CW  = $clog2(MAX_CAL_REVS + 1);
    localparam int unsigned C_DW1 = DATA_WIDTH + 1;

    sync_state_e           state_q, state_d;
    logic [C_GW-1:0]       good_cnt_q, good_cnt_d, w_good_inc;
    logic [C_CW-1:0]       cal_cnt_q, cal_cnt_d, w_cal_inc;
    logic                  eval_q, eval_d;
    logic                  ready_q, ready_d, sim_en_q, sim_en_d;
    logic                  err_timeout_q, err_timeout_d, err_unstable_q, err_unstable_d;
    logic                  lost_lock_q, lost_lock_d;
    logic [15:0]           loss_cnt_q, loss_cnt_d;
    logic [DATA_WIDTH-1:0] lock_arp_q, lock_arp_d, lock_acp_q, lock_acp_d, lock_trig_q, lock_trig_d;
    logic                  w_active, w_clear, w_timeout, w_good, w_lock_bad;
    logic                  w_track_q, w_track_d;
    logic [DATA_WIDTH:0]   w_arp_diff;

    assign w_active = (state_q == ST_WAIT_ARP) || (state_q == ST_CALIBRATING) || (state_q == ST_LOCKED);
    assign w_clear  = (state_q == ST_IDLE);

    arp_watchdog #(
        .TIMEOUT_US (ARP_TIMEOUT_US)
    ) u_arp_watchdog (
        .clk         (SYS_CLK),
        .rst         (RST),
        .i_active    (w_active),
        .i_clear     (w_clear),
        .i_arp_pulse (ARP_PULSE),
        .i_us_tick   (US_TICK),
        .o_timeout   (w_timeout)
    );

    assign w_good = CALIBRATED
                 && (ACP_CNT >= DATA_WIDTH'(ACP_MIN))
                 && (ACP_CNT <= DATA_WIDTH'(ACP_MAX))
                 && (TRIG_CNT >= DATA_WIDTH'(TRIG_MIN));

    assign w_arp_diff = (ARP_US >= lock_arp_q) ? ({1'b0, ARP_US} - {1'b0, lock_arp_q})
                                               : ({1'b0, lock_arp_q} - {1'b0, ARP_US});
    assign w_lock_bad = (w_arp_diff > C_DW1'(ARP_TOL_US)) || (ACP_CNT != lock_acp_q) || !CALIBRATED;

    assign w_good_inc = good_cnt_q + 1'b1;
    assign w_cal_inc  = cal_cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        good_cnt_d     = good_cnt_q;
        cal_cnt_d      = cal_cnt_q;
        err_timeout_d  = err_timeout_q;
        err_unstable_d = err_unstable_q;
        lost_lock_d    = 1'b0;
        loss_cnt_d     = loss_cnt_q;
        lock_arp_d     = lock_arp_q;
        lock_acp_d     = lock_acp_q;
        lock_trig_d    = lock_trig_q;

        if (!ENABLE) begin
            state_d        = ST_IDLE;
            good_cnt_d     = '0;
            cal_cnt_d      = '0;
            err_timeout_d  = 1'b0;
            err_unstable_d = 1'b0;
            lock_arp_d     = '0;
            lock_acp_d     = '0;
            lock_trig_d    = '0;
        end else if (w_timeout) begin
            state_d       = ST_FAULT;
            err_timeout_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_ARP;
                ST_WAIT_ARP: begin
                    if (ARP_PULSE) begin
                        state_d    = ST_CALIBRATING;
                        good_cnt_d = '0;
                        cal_cnt_d  = '0;
                    end
                end
                ST_CALIBRATING: begin
                    if (eval_q) begin
                        cal_cnt_d  = w_cal_inc;
                        good_cnt_d = w_good ? w_good_inc : '0;
                        // Lock wins over the unstable fault on the same revolution.
                        if (w_good && (w_good_inc == C_GW'(LOCK_REVS))) begin
                            state_d     = ST_LOCKED;
                            lock_arp_d  = ARP_US;
                            lock_acp_d  = ACP_CNT;
                            lock_trig_d = TRIG_CNT;
                        end else if (w_cal_inc == C_CW'(MAX_CAL_REVS)) begin
                            state_d        = ST_FAULT;
                            err_unstable_d = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (eval_q && w_lock_bad) begin
                        state_d     = ST_CALIBRATING;
                        lost_lock_d = 1'b1;
                        good_cnt_d  = '0;
                        cal_cnt_d   = '0;
                        if (loss_cnt_q != 16'hFFFF) begin
                            loss_cnt_d = loss_cnt_q + 16'd1;
                        end
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // The eval strobe follows ARP by one cycle so statistics can settle; it is
    // dropped if the state machine is leaving the tracking states.
    assign w_track_q = (state_q == ST_CALIBRATING) || (state_q == ST_LOCKED);
    assign w_track_d = (state_d == ST_CALIBRATING) || (state_d == ST_LOCKED);
    assign eval_d    = ARP_PULSE && w_track_q && w_track_d;
    assign ready_d   = (state_d == ST_LOCKED);
    assign sim_en_d  = (state_d == ST_LOCKED);

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            good_cnt_q     <= '0;
            cal_cnt_q      <= '0;
            eval_q         <= 1'b0;
            ready_q        <= 1'b0;
            sim_en_q       <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_unstable_q <= 1'b0;
            lost_lock_q    <= 1'b0;
            loss_cnt_q     <= '0;
            lock_arp_q     <= '0;
            lock_acp_q     <= '0;
            lock_trig_q    <= '0;
        end else begin
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
            cal_cnt_q      <= cal_cnt_d;
            eval_q         <= eval_d;
            ready_q        <= ready_d;
            sim_en_q       <= sim_en_d;
            err_timeout_q  <= err_timeout_d;
            err_unstable_q <= err_unstable_d;
            lost_lock_q    <= lost_lock_d;
            loss_cnt_q     <= loss_cnt_d;
            lock_arp_q     <= lock_arp_d;
            lock_acp_q     <= lock_acp_d;
            lock_trig_q    <= lock_trig_d;
        end
    end

    assign STATE         = state_q;
    assign READY         = ready_q;
    assign SIM_EN        = sim_en_q;
    assign ERR_TIMEOUT   = err_timeout_q;
    assign ERR_UNSTABLE  = err_unstable_q;
    assign LOST_LOCK     = lost_lock_q;
    assign LOSS_CNT      = loss_cnt_q;
    assign LOCK_ARP_US   = lock_arp_q;
    assign LOCK_ACP_CNT  = lock_acp_q;
    assign LOCK_TRIG_CNT = lock_trig_q;

endmodule
`default_nettype wire

// File: tb/tb_radar_sync_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_radar_sync_controller
// Brief    : Directed and randomized bench for radar_sync_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radar_sync_controller;

    localparam int P_DW      = 32;
    localparam int P_LOCK    = 3;
    localparam int P_MAXCAL  = 8;
    localparam int P_TMO     = 100;
    localparam int P_ACP_MIN = 4;
    localparam int P_ACP_MAX = 64;
    localparam int P_TRIG_MIN = 1;
    localparam int P_TOL     = 2;

    logic            clk = 1'b0;
    logic            rst, enable, arp_pulse, us_tick, calibrated;
    logic [P_DW-1:0] arp_us, acp_cnt, trig_cnt;
    logic [2:0]      STATE;
    logic            READY, SIM_EN, ERR_TIMEOUT, ERR_UNSTABLE, LOST_LOCK;
    logic [15:0]     LOSS_CNT;
    logic [P_DW-1:0] LOCK_ARP_US, LOCK_ACP_CNT, LOCK_TRIG_CNT;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int     m_state, m_timer, m_good, m_cal, m_loss;
    bit     m_eval, m_err_to, m_err_un, m_lost;
    longint m_lock_arp, m_lock_acp, m_lock_trig;

    always #5 clk = ~clk;

    radar_sync_controller #(
        .DATA_WIDTH(P_DW), .LOCK_REVS(P_LOCK), .MAX_CAL_REVS(P_MAXCAL),
        .ARP_TIMEOUT_US(P_TMO), .ACP_MIN(P_ACP_MIN), .ACP_MAX(P_ACP_MAX),
        .TRIG_MIN(P_TRIG_MIN), .ARP_TOL_US(P_TOL)
    ) dut (
        .SYS_CLK(clk), .RST(rst), .ENABLE(enable), .ARP_PULSE(arp_pulse),
        .US_TICK(us_tick), .CALIBRATED(calibrated), .ARP_US(arp_us),
        .ACP_CNT(acp_cnt), .TRIG_CNT(trig_cnt), .STATE(STATE), .READY(READY),
        .SIM_EN(SIM_EN), .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_UNSTABLE(ERR_UNSTABLE),
        .LOST_LOCK(LOST_LOCK), .LOSS_CNT(LOSS_CNT), .LOCK_ARP_US(LOCK_ARP_US),
        .LOCK_ACP_CNT(LOCK_ACP_CNT), .LOCK_TRIG_CNT(LOCK_TRIG_CNT)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Revolution-level rules applied at each clock edge to the inputs present.
    task automatic model_edge();
        bit     watching, tracking, timed_out, do_eval, in_range, lock_off;
        int     nxt;
        longint drift;
        if (rst) begin
            m_state = 0; m_timer = 0; m_good = 0; m_cal = 0; m_loss = 0;
            m_eval = 0; m_err_to = 0; m_err_un = 0; m_lost = 0;
            m_lock_arp = 0; m_lock_acp = 0; m_lock_trig = 0;
            return;
        end
        watching  = (m_state >= 1 && m_state <= 3);
        tracking  = (m_state == 2 || m_state == 3);
        timed_out = watching && (m_timer == P_TMO) && !arp_pulse;
        do_eval   = m_eval && tracking;
        in_range  = calibrated && (acp_cnt >= P_ACP_MIN) && (acp_cnt <= P_ACP_MAX) && (trig_cnt >= P_TRIG_MIN);
        drift     = longint'(arp_us) - m_lock_arp;
        if (drift < 0) drift = -drift;
        lock_off  = (drift > P_TOL) || (longint'(acp_cnt) != m_lock_acp) || !calibrated;
        nxt       = m_state;
        m_lost    = 0;

        if (m_state == 0) m_timer = 0;
        else if (watching) begin
            if (arp_pulse) m_timer = us_tick ? 1 : 0;
            else if (us_tick && m_timer < P_TMO) m_timer++;
        end

        if (!enable) begin
            nxt = 0; m_good = 0; m_cal = 0; m_err_to = 0; m_err_un = 0;
            m_lock_arp = 0; m_lock_acp = 0; m_lock_trig = 0;
        end else if (m_state == 0) begin
            nxt = 1;
        end else if (timed_out) begin
            nxt = 4; m_err_to = 1;
        end else if (m_state == 1 && arp_pulse) begin
            nxt = 2; m_good = 0; m_cal = 0;
        end else if (m_state == 2 && do_eval) begin
            m_cal++;
            m_good = in_range ? m_good + 1 : 0;
            if (m_good == P_LOCK) begin
                nxt = 3; m_lock_arp = arp_us; m_lock_acp = acp_cnt; m_lock_trig = trig_cnt;
            end else if (m_cal == P_MAXCAL) begin
                nxt = 4; m_err_un = 1;
            end
        end else if (m_state == 3 && do_eval && lock_off) begin
            nxt = 2; m_lost = 1; m_good = 0; m_cal = 0;
            if (m_loss < 65535) m_loss++;
        end
        m_eval  = arp_pulse && tracking && (nxt == 2 || nxt == 3);
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("state",        64'(STATE),         64'(m_state));
        chk("ready",        64'(READY),         64'(m_state == 3));
        chk("sim_en",       64'(SIM_EN),        64'(m_state == 3));
        chk("err_timeout",  64'(ERR_TIMEOUT),   64'(m_err_to));
        chk("err_unstable", 64'(ERR_UNSTABLE),  64'(m_err_un));
        chk("lost_lock",    64'(LOST_LOCK),     64'(m_lost));
        chk("loss_cnt",     64'(LOSS_CNT),      64'(m_loss));
        chk("lock_arp",     64'(LOCK_ARP_US),   64'(m_lock_arp));
        chk("lock_acp",     64'(LOCK_ACP_CNT),  64'(m_lock_acp));
        chk("lock_trig",    64'(LOCK_TRIG_CNT), 64'(m_lock_trig));
    endtask

    task automatic cyc(input bit arp, input bit tick);
        arp_pulse = arp;
        us_tick   = tick;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_us(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic arp_eval();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic rev(input int period);
        arp_eval();
        run_us(period);
    endtask

    task automatic restart();
        enable = 1'b0; cyc(1'b0, 1'b0);
        enable = 1'b1; cyc(1'b0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation bound exceeded");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; arp_pulse = 1'b0; us_tick = 1'b0;
        calibrated = 1'b0; arp_us = '0; acp_cnt = '0; trig_cnt = '0;
        cyc(1'b0, 1'b0);
        chk("reset_state", 64'(STATE), 64'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);

        // Nominal lock
        arp_us = 50; acp_cnt = 16; trig_cnt = 4; calibrated = 1'b1;
        enable = 1'b1; cyc(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rev(50);
        chk("t1_state",    64'(STATE),        64'd3);
        chk("t1_sim_en",   64'(SIM_EN),       64'd1);
        chk("t1_lock_arp", 64'(LOCK_ARP_US),  64'd50);
        chk("t1_lock_acp", 64'(LOCK_ACP_CNT), 64'd16);

        // Drift beyond tolerance, then relock at the new period
        arp_us = 53;
        arp_eval();
        chk("t2_lost_pulse", 64'(LOST_LOCK), 64'd1);
        chk("t2_state",      64'(STATE),     64'd2);
        chk("t2_sim_en",     64'(SIM_EN),    64'd0);
        chk("t2_loss_cnt",   64'(LOSS_CNT),  64'd1);
        cyc(1'b0, 1'b0);
        chk("t2_lost_clear", 64'(LOST_LOCK), 64'd0);
        run_us(50);
        arp_us = 52;
        for (int i = 0; i < 3; i++) rev(50);
        chk("t2_relock",     64'(STATE),       64'd3);
        chk("t2_lock_arp",   64'(LOCK_ARP_US), 64'd52);

        // Unstable calibration
        restart();
        rev(50);
        for (int k = 0; k < P_MAXCAL; k++) begin
            calibrated = (k % 3 != 2);
            rev(50);
        end
        chk("t3_state",  64'(STATE),        64'd4);
        chk("t3_err_un", 64'(ERR_UNSTABLE), 64'd1);
        enable = 1'b0; cyc(1'b0, 1'b0);
        calibrated = 1'b1;
        chk("t3_idle",       64'(STATE),        64'd0);
        chk("t3_err_clear",  64'(ERR_UNSTABLE), 64'd0);
        chk("t3_loss_holds", 64'(LOSS_CNT),     64'd1);

        // ARP timeout, and ARP coinciding with the limiting tick
        enable = 1'b1; cyc(1'b0, 1'b0);
        run_us(P_TMO);
        chk("t4_state",  64'(STATE),       64'd4);
        chk("t4_err_to", 64'(ERR_TIMEOUT), 64'd1);
        restart();
        run_us(P_TMO - 1);
        cyc(1'b1, 1'b1);
        chk("t4_arp_wins",   64'(STATE),       64'd2);
        chk("t4_no_err",     64'(ERR_TIMEOUT), 64'd0);
        cyc(1'b0, 1'b0);
        run_us(P_TMO - 2);
        chk("t4_timer_one",  64'(STATE),       64'd2);
        run_us(1);
        chk("t4_late_fault", 64'(STATE),       64'd4);

        // ACP just out of range never locks; upper bound does
        restart();
        arp_us = 50; acp_cnt = 65; trig_cnt = 4;
        rev(50);
        for (int i = 0; i < P_MAXCAL - 1; i++) rev(50);
        chk("t5_not_yet",  64'(STATE),        64'd2);
        rev(50);
        chk("t5_fault",    64'(STATE),        64'd4);
        chk("t5_err_un",   64'(ERR_UNSTABLE), 64'd1);
        restart();
        acp_cnt = 64;
        for (int i = 0; i < 4; i++) rev(50);
        chk("t5_lock",     64'(STATE),        64'd3);
        chk("t5_lock_acp", 64'(LOCK_ACP_CNT), 64'd64);

        // Accumulate losses, then reset while locked
        for (int i = 0; i < 4; i++) begin
            arp_us = (i % 2 == 0) ? 53 : 50;
            for (int j = 0; j < 4; j++) rev(50);
        end
        chk("t6_loss5",  64'(LOSS_CNT), 64'd5);
        chk("t6_locked", 64'(STATE),    64'd3);
        rst = 1'b1; cyc(1'b0, 1'b0);
        chk("t6_state",    64'(STATE),       64'd0);
        chk("t6_loss_clr", 64'(LOSS_CNT),    64'd0);
        chk("t6_sim_en",   64'(SIM_EN),      64'd0);
        chk("t6_lock_arp", 64'(LOCK_ARP_US), 64'd0);
        rst = 1'b0;

        // Randomized revolutions against the model
        enable = 1'b1; cyc(1'b0, 1'b0);
        for (int r = 0; r < 80; r++) begin
            arp_us     = 48 + $urandom_range(0, 6);
            acp_cnt    = ($urandom_range(0, 99) < 85) ? 32 : $urandom_range(0, 80);
            trig_cnt   = $urandom_range(0, 7);
            calibrated = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) run_us(P_TMO + 1);
            rev($urandom_range(5, 40));
            if (m_state == 4 || $urandom_range(0, 39) == 0) restart();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/radar_sync_controller.md
Name: radar_sync_controller

Overview:
Sequences radar-input calibration ahead of the simulator datapath. It consumes the per-revolution statistics (ARP period in µs, ACP count, TRIG count, CALIBRATED flag) and the synchronized ARP and µs tick pulses. It declares lock after N consecutive stable, in-range revolutions, then gates the simulator with SIM_EN. It also watches for lock loss and ARP timeout.

Parameters:
DATA_WIDTH, 32, width of statistics inputs and latched values
LOCK_REVS, 3, consecutive good revolutions required for lock
MAX_CAL_REVS, 16, evaluated revolutions allowed in CALIBRATING before fault
ARP_TIMEOUT_US, 20000000, µs without an ARP pulse before fault
ACP_MIN, 256, minimum legal ACP_CNT
ACP_MAX, 8192, maximum legal ACP_CNT
TRIG_MIN, 1, minimum legal TRIG_CNT
ARP_TOL_US, 1000, allowed |ARP_US - LOCK_ARP_US| while locked

Ports:
SYS_CLK  in  1  system clock
RST  in  1  synchronous active-high reset
ENABLE  in  1  level; 1 = run calibration/sync sequence
ARP_PULSE  in  1  one-cycle pulse on ARP rising edge (SYS_CLK domain)
US_TICK  in  1  one-cycle pulse per µs (SYS_CLK domain)
CALIBRATED  in  1  statistics-block stability flag
ARP_US  in  DATA_WIDTH  µs per revolution
ACP_CNT  in  DATA_WIDTH  ACPs per revolution
TRIG_CNT  in  DATA_WIDTH  TRIGs per ACP
STATE  out  3  current state encoding
READY  out  1  1 while LOCKED
SIM_EN  out  1  simulator enable, 1 only in LOCKED
ERR_TIMEOUT  out  1  sticky, ARP timeout fault
ERR_UNSTABLE  out  1  sticky, calibration did not converge
LOST_LOCK  out  1  one-cycle pulse on LOCKED -> CALIBRATING
LOSS_CNT  out  16  lock-loss count, saturates at 16'hFFFF
LOCK_ARP_US  out  DATA_WIDTH  ARP_US latched at lock
LOCK_ACP_CNT  out  DATA_WIDTH  ACP_CNT latched at lock
LOCK_TRIG_CNT  out  DATA_WIDTH  TRIG_CNT latched at lock

Behaviour:
- Reset: STATE=IDLE. All outputs, counters, timer and eval flag are 0. Reset mid-operation aborts immediately, errors included.
- All outputs are registered.
- States: IDLE(0), WAIT_ARP(1), CALIBRATING(2), LOCKED(3), FAULT(4).
- ENABLE=0 in any state -> IDLE on the next edge. On that transition, errors, LOCK_* and rev counters clear. LOSS_CNT holds; it is cleared only by RST.
- IDLE -> WAIT_ARP when ENABLE=1. The timer clears.
- WAIT_ARP: ignores statistics, because the first revolution is partial. On ARP_PULSE -> CALIBRATING with good_cnt=0 and cal_cnt=0.
- Eval strobe: asserted the cycle after ARP_PULSE in CALIBRATING or LOCKED. This lets the statistics registers settle.
- Range check ("good"): CALIBRATED=1 and ACP_MIN <= ACP_CNT <= ACP_MAX and TRIG_CNT >= TRIG_MIN.
- CALIBRATING, on eval:
  - cal_cnt++.
  - If good, good_cnt++; else good_cnt=0.
  - If good_cnt+1 == LOCK_REVS -> LOCKED next cycle, and LOCK_* latch the current inputs.
  - Else, if cal_cnt+1 == MAX_CAL_REVS -> FAULT with ERR_UNSTABLE=1.
  - Lock takes priority over the unstable fault on the same eval.
- LOCKED, on eval:
  - Compute |ARP_US - LOCK_ARP_US| at DATA_WIDTH+1 bits, unsigned, no wrap.
  - If that value > ARP_TOL_US, or ACP_CNT != LOCK_ACP_CNT, or !CALIBRATED -> CALIBRATING next cycle.
  - On that transition: SIM_EN=0 in the same cycle STATE leaves LOCKED, LOST_LOCK pulses, LOSS_CNT++ (saturating), good_cnt=0, cal_cnt=0.
- Watchdog (active in WAIT_ARP, CALIBRATING, LOCKED):
  - timer++ on US_TICK; timer=0 on ARP_PULSE.
  - ARP_PULSE together with US_TICK gives timer=1.
  - timer saturates at ARP_TIMEOUT_US.
  - When timer == ARP_TIMEOUT_US and ARP_PULSE=0 -> FAULT with ERR_TIMEOUT=1. ARP_PULSE in the same cycle wins.
  - Timeout has priority over eval transitions.
- FAULT: SIM_EN=0, READY=0, errors held. Exit only via ENABLE=0 or RST.
- Eval pending when the state leaves CALIBRATING/LOCKED: discarded.

Decomposition:
- Shared package/header radar_sync_pkg holds the state encodings (IDLE..FAULT) and STATE width 3.
- Sub-module arp_watchdog: timer, saturation and timeout flag, with inputs ARP_PULSE, US_TICK, active and clear.
- The FSM, range checks and latches stay in radar_sync_controller.

Test Plan:
Bench parameters: LOCK_REVS=3, MAX_CAL_REVS=8, ARP_TIMEOUT_US=100, ACP_MIN=4, ACP_MAX=64, TRIG_MIN=1, ARP_TOL_US=2.
1. ENABLE=1; ARP every 50 µs; ACP_CNT=16, TRIG_CNT=4, CALIBRATED=1 -> after the first ARP plus 3 evals, STATE=3, SIM_EN=1, LOCK_ARP_US=50, LOCK_ACP_CNT=16.
2. Locked; set ARP_US=53 at the next eval -> LOST_LOCK one cycle, STATE=2, SIM_EN=0, LOSS_CNT=1. Then ARP_US=52 for 3 revs -> relock with LOCK_ARP_US=52.
3. CALIBRATED toggles 1,1,0,1,1,0 repeatedly -> after 8 evals STATE=4, ERR_UNSTABLE=1. ENABLE=0 -> STATE=0, ERR_UNSTABLE=0.
4. No ARP for 100 US_TICKs in WAIT_ARP -> STATE=4, ERR_TIMEOUT=1. ARP and the 100th tick in the same cycle -> no fault, timer=1.
5. ACP_CNT=65, CALIBRATED=1 -> never locks; good_cnt stays 0; ERR_UNSTABLE after 8 evals. ACP_CNT=64 -> locks.
6. RST asserted while LOCKED with LOSS_CNT=5 -> next cycle all outputs 0 and STATE=0.
